// File: rtl/cam_soc_pio_out_ext_if.sv
// Avalon-MM slave bus for the cam_soc output PIO.
// Zero wait states; readdata is a combinational function of address.
interface cam_soc_pio_out_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/cam_soc_pio_out_ext.sv
// Output PIO with atomic SET/CLEAR/TOGGLE and masked auto-clear pulses.
// One shared down-counter times every masked bit; a write always beats expiry.
module cam_soc_pio_out_ext #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PULSE_LEN   = 4,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cam_soc_pio_out_ext_if.slave bus,
  output logic [WIDTH-1:0]     out_port,
  output logic                 pulse_busy
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TOG    = 3'd3;
  localparam logic [2:0] A_MASK   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_en;
  logic             wr_data;
  logic             wr_set;
  logic             wr_clr;
  logic             wr_tog;
  logic             wr_mask;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] d1;
  logic             expire;
  logic             reload;
  logic [31:0]      status;
  logic [31:0]      rd;
  logic             unused_wd;

  // Upper writedata bits are don't-care for narrow ports.
  assign unused_wd = ^bus.writedata;

  always_comb begin
    wr_en   = bus.chipselect & ~bus.write_n;
    wd      = bus.writedata[WIDTH-1:0];
    wr_data = wr_en && (bus.address == A_DATA);
    wr_set  = wr_en && (bus.address == A_SET);
    wr_clr  = wr_en && (bus.address == A_CLR);
    wr_tog  = wr_en && (bus.address == A_TOG);
    wr_mask = wr_en && (bus.address == A_MASK);
  end

  // Expiry is applied first so a same-edge write overrides it.
  always_comb begin
    expire = (cnt_q == CNT_ONE);
    d1     = expire ? (data_q & ~mask_q) : data_q;
    data_d = d1;
    unique case (1'b1)
      wr_data: data_d = wd;
      wr_set:  data_d = d1 | wd;
      wr_clr:  data_d = d1 & ~wd;
      wr_tog:  data_d = d1 ^ wd;
      default: data_d = d1;
    endcase
  end

  always_comb begin
    mask_d = wr_mask ? wd : mask_q;
    reload = (wr_data | wr_set | wr_tog)
           && ((data_d & mask_q) != '0);
    cnt_d  = cnt_q;
    if (reload) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_port   = data_q;
  assign pulse_busy = (cnt_q != '0);

  always_comb begin
    status       = '0;
    status[31:16] = 16'(cnt_q);
    status[0]    = pulse_busy;
    rd           = '0;
    unique case (bus.address)
      A_DATA:   rd = 32'(data_q);
      A_MASK:   rd = 32'(mask_q);
      A_STATUS: rd = status;
      default:  rd = '0;
    endcase
  end

  assign bus.readdata = rd;

endmodule

// File: doc/cam_soc_pio_out_ext.md
Name: cam_soc_pio_out_ext

Overview:
Parametrised Avalon-MM output PIO for the cam_soc fabric. It is the successor to the fixed 2-bit hardware-signal output port. It adds:
- configurable width and reset value
- atomic SET/CLEAR/TOGGLE registers
- a per-bit auto-clearing pulse mode, timed by one shared down-counter

It sits between the Nios II data master and hardware control strobes (camera/encryption start, FIFO flush, etc.). Firmware can issue fixed-length pulses without read-modify-write races.

Parameters:
WIDTH, 8, output port width; legal 1..32.
RESET_VALUE, 0, value of out_port after reset; WIDTH bits.
PULSE_LEN, 4, length in clk cycles of an auto-clear pulse; legal 1..65535.
CNT_W, 16, counter width; must satisfy 2^CNT_W > PULSE_LEN.

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  3  word address of register.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe; zero wait states.
writedata  in  32  write data; bits [31:WIDTH] ignored.
readdata  out  32  combinational read data; unused bits 0.
out_port  out  WIDTH  registered output bits.
pulse_busy  out  1  high while the pulse counter is nonzero.

Behaviour:
- Reset state (async, active-high): data=RESET_VALUE, mask=0, cnt=0. Hence out_port=RESET_VALUE and pulse_busy=0. Reset mid-pulse aborts the pulse immediately.
- A write is accepted on a rising edge when chipselect=1 and write_n=0. Takes effect on out_port at that edge; latency 1 edge, no wait states.
- Address map:
  0 DATA: R/W; write sets data=wd.
  1 SET: W only; data|=wd.
  2 CLEAR: W only; data&=~wd.
  3 TOGGLE: W only; data^=wd.
  4 PULSE_MASK: R/W; mask=wd.
  5 STATUS: RO; bit0=pulse_busy, bits[31:16]=cnt zero-extended.
  Addresses 1, 2, 3, 6, 7 read 0. Writes to 5/6/7 are ignored.
- readdata is a combinational mux of address; chipselect does not gate it.
- Next-state order within one edge:
  1. expire = (cnt==1). If expire, d1=data&~mask; else d1=data.
  2. Apply the write op (if any) to d1 → d2; data<=d2.
  3. Counter:
     - reload: DATA/SET/TOGGLE write with (d2&mask)!=0 → cnt<=PULSE_LEN;
     - else if cnt!=0 → cnt<=cnt-1;
     - else hold 0.
  Reload takes precedence over decrement and over the expire transition.
- Consequence: a masked bit set by write at edge T is high for exactly PULSE_LEN cycles and falls at edge T+PULSE_LEN.
- Retriggering (SET while busy) restarts the full PULSE_LEN window for all masked bits.
- Expiry clears every bit in the mask at expiry time. Mask changes during a pulse apply at expiry and do not touch cnt.
- A CLEAR of all masked bits while busy does not stop the counter. The counter runs out harmlessly.
- Bits outside the mask are never auto-cleared.
- With mask=0 the block behaves as a plain registered PIO. pulse_busy never asserts.
- The write-vs-expire collision on the same edge is resolved by the ordering above: write wins.

Test Plan:
Defaults used: WIDTH=8, PULSE_LEN=4, RESET_VALUE=0x00.
1. Reset/plain: assert reset mid-cycle → out_port=0x00, STATUS=0 immediately. Write DATA=0x1A5 → out_port=0xA5 next edge; read addr0=0x000000A5.
2. Set/clear/toggle: from 0xA5, SET 0x0F → 0xAF; CLEAR 0x81 → 0x2E; TOGGLE 0xFF → 0xD1. Reads of addr1..3 return 0.
3. Pulse: MASK=0x01, SET 0x03 at edge T:
   - out_port=0x03 for edges T..T+3, then 0x02 from T+4;
   - pulse_busy high 4 cycles;
   - STATUS[31:16] reads 4, 3, 2, 1, 0.
4. Retrigger/collision:
   - SET 0x01 at T, SET 0x01 again at T+2 → bit0 falls at T+6.
   - DATA=0x01 written on the expiry edge → bit0 stays 1, cnt reloads to 4.
5. Reset mid-pulse: MASK=0xFF, DATA=0xFF, assert reset after 2 cycles → out_port=0x00, cnt=0, mask=0 asynchronously. No spurious pulse after release.
6. Width edge: instantiate WIDTH=32, RESET_VALUE=0x80000001 → out_port=0x80000001 after reset. CLEAR 0xFFFFFFFF → 0. Writes to addr 6/7 change nothing.
